seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Seven-segment output stage downstream of the scan/page divider. It consumes the divider's active-low digit select `sel_in` (1 kHz rotation) and `page_in` (1 s toggle) and shows an 8-digit hex value on a 4-digit display, four digits per page. The value is double-buffered so updates land only on page boundaries. Anodes are blanked briefly on every select/page change to suppress ghosting, and leading zeros are optionally suppressed.

## Interface
- `BLANK_CYCLES`, 1000: anode-off cycles after each select/page change; 0 disables blanking.
- `LZB`, 1: 1 suppresses leading zeros across all 8 digits; digit 0 is never suppressed.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `sel_in`  in  4  active-low one-hot digit select from the divider; 1110 = rightmost.
- `page_in`  in  1  page flag from the divider; 1 = upper nibbles 7..4, 0 = nibbles 3..0.
- `data_in`  in  32  value to display, nibble k = digit k.
- `dot_in`  in  8  decimal point per digit, 1 = lit.
- `load`  in  1  single-cycle strobe; captures `data_in`/`dot_in` into the shadow.
- `an`  out  4  registered anode drive, active-low.
- `seg`  out  7  registered segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  registered decimal point, active-low.
- `pending`  out  1  shadow holds data not yet displayed.

## Operation
- Reset values: `an`=1111, `seg`=1111111, `dp`=1, `pending`=0, shadow=0, active=0, `sel_q`=1111, `page_q`=`page_in` sampled in the reset cycle, blank counter=0.
- `load`=1: shadow ← {`data_in`,`dot_in`}; `pending` ← 1.
- Page edge: any edge where `page_in`≠`page_q`. If `pending`, active ← shadow and `pending` ← 0.
- `load` coincident with a page edge: active ← {`data_in`,`dot_in`} directly, shadow is updated too, and `pending` ends at 0.
- Digit index: idx = {`page_in`, pos}, where pos = 0,1,2,3 for `sel_in` = 1110, 1101, 1011, 0111.
- Invalid `sel_in` (not exactly one zero bit): `an`=1111, `seg`=1111111, `dp`=1 while invalid; no blanking counter start.
- Leading-zero rule (`LZB`=1): digit k>0 is blank when active nibbles k..7 are all 0.
  - Blank means `seg`=1111111.
  - `dp` still follows `dot_in[k]`.
- Decode (hex to active-low segments): 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110; remaining glyphs are the standard hex set.
- Blanking:
  - Trigger: an edge with `sel_in`≠`sel_q` or a page edge (valid `sel_in`).
  - On the trigger: counter ← `BLANK_CYCLES`, `an` ← 1111, and `seg`/`dp` load the new digit on that same edge.
  - While counter>0: it decrements each cycle and `an` stays 1111.
  - When counter reaches 0: `an` ← `sel_q`.
  - A new trigger during blanking reloads the counter.

## Timing
- With `BLANK_CYCLES`=N≥1: `sel_in` changes before edge t. `an`=1111 for cycles t..t+N. `an`=new select from t+N+1.
- With `BLANK_CYCLES`=0: `an`/`seg` follow `sel_in` with 1-cycle latency.
- `seg`/`dp` reflect a new active value 1 cycle after the page edge that transfers it.
- `pending` rises 1 cycle after `load` and falls 1 cycle after the transferring page edge.
- `rst` mid-blank or mid-pending clears everything; the display shows "0" on digit 0 of page 0 once `sel_in` is valid and blanking has expired.

## Structure
- Shared package `seg_pkg`:
  - `SEG_OFF`=7'b1111111 and `AN_OFF`=4'b1111.
  - Hex-glyph constants.
  - Counter width function `$clog2(BLANK_CYCLES+1)`.
- One combinational sub-module `seg7_decode` (4-bit nibble → 7-bit active-low segments), instantiated once.
- Top block holds: shadow/active registers, page-edge detect, LZB mask, blank counter, output registers.

## Test plan
- Reset, `sel_in`=1110, `page_in`=0, N=4 → after blank, `an`=1110, `seg`=1000000, `dp`=1, `pending`=0.
- `load` with `data_in`=0x1234ABCF, `page_in` held → `pending`=1 and display unchanged. Toggle `page_in` to 1 → `pending`=0; `sel_in`=1110 shows nibble 4 = 4 (0011001).
- `data_in`=0x0000000A, LZB=1, `page_in`=1 → all four digits `seg`=1111111. On page 0: `sel_in`=1110 shows A (0001000), 1101 blank.
- `sel_in` 1110→1101 with N=4 → `an`=1111 for exactly 5 cycles, then 1101. A second change mid-blank restarts the 5-cycle window.
- `load` on the same cycle as a page edge with `data_in`=0x88888888 → 8 (0000000) displayed the next cycle and `pending`=0. `sel_in`=1100 → `an`=1111 and `seg`=1111111.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, glyphs and helpers for the seven-segment scan driver
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dot;
    } disp_word_t;

    // A zero-cycle blank still needs a 1-bit counter so the register is legal
    function automatic int cnt_width(input int blank_cycles);
        int w;
        w = $clog2(blank_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - hex nibble to active-low seven-segment glyph
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (nibble_i)
            4'h0: seg_o = GLYPH_0;
            4'h1: seg_o = GLYPH_1;
            4'h2: seg_o = GLYPH_2;
            4'h3: seg_o = GLYPH_3;
            4'h4: seg_o = GLYPH_4;
            4'h5: seg_o = GLYPH_5;
            4'h6: seg_o = GLYPH_6;
            4'h7: seg_o = GLYPH_7;
            4'h8: seg_o = GLYPH_8;
            4'h9: seg_o = GLYPH_9;
            4'hA: seg_o = GLYPH_A;
            4'hB: seg_o = GLYPH_B;
            4'hC: seg_o = GLYPH_C;
            4'hD: seg_o = GLYPH_D;
            4'hE: seg_o = GLYPH_E;
            4'hF: seg_o = GLYPH_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - double-buffered 8-digit hex scan output with anti-ghost blanking
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int BLANK_CYCLES = 1000,
    parameter bit LZB          = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sel_in,
    input  logic        page_in,
    input  logic [31:0] data_in,
    input  logic [7:0]  dot_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        pending
);

    localparam int             CW         = cnt_width(BLANK_CYCLES);
    localparam logic [CW-1:0]  BLANK_LOAD = CW'(BLANK_CYCLES);

    disp_word_t    shadow_q, shadow_d;
    disp_word_t    active_q, active_d;
    logic          pending_q, pending_d;
    logic [3:0]    sel_q;
    logic          page_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          page_edge;
    logic          sel_valid;
    logic          trigger;
    logic [1:0]    pos;
    logic [2:0]    idx;
    logic [3:0]    nibble;
    logic [6:0]    glyph;
    logic [7:0]    zero_from;
    logic          digit_blank;
    disp_word_t    load_word;

    seg7_decode u_decode (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    // Buffer transfer: a load coinciding with a page edge bypasses the shadow
    always_comb begin
        page_edge = (page_in != page_q);
        load_word = disp_word_t'({data_in, dot_in});
        shadow_d  = load ? load_word : shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (page_edge && load) begin
            active_d  = load_word;
            pending_d = 1'b0;
        end else if (page_edge && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Digit selection and leading-zero mask are taken from the value that lands this edge
    always_comb begin
        sel_valid = $onehot(~sel_in);
        pos       = 2'd0;
        case (sel_in)
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            4'b0111: pos = 2'd3;
            default: pos = 2'd0;
        endcase
        idx    = {page_in, pos};
        nibble = active_d.data[{idx, 2'b00} +: 4];
        for (int k = 0; k < 8; k++) begin
            zero_from[k] = ((active_d.data >> (4 * k)) == 32'd0);
        end
        digit_blank = LZB && (idx != 3'd0) && zero_from[idx];
        trigger     = sel_valid && ((sel_in != sel_q) || page_edge);
    end

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        cnt_d = cnt_q;
        if (!sel_valid) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end else begin
            seg_d = digit_blank ? SEG_OFF : glyph;
            dp_d  = ~active_d.dot[idx];
            if (trigger && (BLANK_CYCLES > 0)) begin
                cnt_d = BLANK_LOAD;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                an_d = sel_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            sel_q     <= AN_OFF;
            page_q    <= page_in;
            cnt_q     <= '0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            sel_q     <= sel_in;
            page_q    <= page_in;
            cnt_q     <= cnt_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver with a behavioural display model
module tb_seg_scan_driver;

    localparam int N = 4;

    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sel_in = 4'b1110;
    logic        page_in = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  dot_in = '0;
    logic        load = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        pending;

    int n_cmp = 0;
    int n_bad = 0;

    seg_scan_driver #(.BLANK_CYCLES(N), .LZB(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .sel_in  (sel_in),
        .page_in (page_in),
        .data_in (data_in),
        .dot_in  (dot_in),
        .load    (load),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: displayed value, pending flag and blanking window by cycle arithmetic
    logic        m_live = 1'b0;
    logic [31:0] m_sh_data, m_act_data;
    logic [7:0]  m_sh_dot, m_act_dot;
    logic        m_pend;
    logic [3:0]  m_prev_sel;
    logic        m_prev_page;
    int          m_cyc, m_last_trig;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    always @(posedge clk) begin
        logic       pe;
        logic [3:0] nsel;
        int         pos, k;
        m_cyc++;
        if (rst) begin
            m_live      = 1'b1;
            m_sh_data   = '0;
            m_sh_dot    = '0;
            m_act_data  = '0;
            m_act_dot   = '0;
            m_pend      = 1'b0;
            m_prev_sel  = 4'b1111;
            m_prev_page = page_in;
            m_last_trig = m_cyc - 1000;
            e_an        = 4'b1111;
            e_seg       = 7'b1111111;
            e_dp        = 1'b1;
        end else begin
            pe = (page_in != m_prev_page);
            if (load && pe) begin
                m_act_data = data_in;
                m_act_dot  = dot_in;
            end else if (pe && m_pend) begin
                m_act_data = m_sh_data;
                m_act_dot  = m_sh_dot;
            end
            if (load) begin
                m_sh_data = data_in;
                m_sh_dot  = dot_in;
            end
            if (pe) m_pend = 1'b0;
            else if (load) m_pend = 1'b1;
            nsel = ~sel_in;
            if ($countones(nsel) == 1) begin
                pos = 0;
                for (int p = 0; p < 4; p++) if (nsel[p]) pos = p;
                k = (page_in ? 4 : 0) + pos;
                if (sel_in != m_prev_sel || pe) m_last_trig = m_cyc;
                if (k > 0 && (m_act_data >> (4 * k)) == 0) e_seg = 7'b1111111;
                else e_seg = HEX_GLYPH[(m_act_data >> (4 * k)) & 32'hF];
                e_dp = ~m_act_dot[k];
                e_an = (m_cyc - m_last_trig <= N) ? 4'b1111 : sel_in;
            end else begin
                e_an  = 4'b1111;
                e_seg = 7'b1111111;
                e_dp  = 1'b1;
            end
            m_prev_sel  = sel_in;
            m_prev_page = page_in;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_an", {28'd0, an}, {28'd0, e_an});
            check("model_seg", {25'd0, seg}, {25'd0, e_seg});
            check("model_dp", {31'd0, dp}, {31'd0, e_dp});
            check("model_pending", {31'd0, pending}, {31'd0, m_pend});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] sels [4];
        sels[0] = 4'b1110; sels[1] = 4'b1101; sels[2] = 4'b1011; sels[3] = 4'b0111;
        m_cyc = 0;

        tick();
        check("reset_an", {28'd0, an}, 32'hF);
        check("reset_seg", {25'd0, seg}, 32'h7F);
        check("reset_dp", {31'd0, dp}, 32'd1);
        check("reset_pending", {31'd0, pending}, 32'd0);
        rst = 1'b0;
        repeat (8) tick();
        check("zero_an", {28'd0, an}, 32'hE);
        check("zero_seg", {25'd0, seg}, 32'h40);
        check("zero_dp", {31'd0, dp}, 32'd1);

        data_in = 32'h1234ABCF; load = 1'b1;
        tick();
        load = 1'b0;
        check("load_pending", {31'd0, pending}, 32'd1);
        check("load_held_seg", {25'd0, seg}, 32'h40);
        page_in = 1'b1;
        tick();
        check("xfer_pending", {31'd0, pending}, 32'd0);
        check("xfer_seg_nib4", {25'd0, seg}, 32'h19);

        data_in = 32'h0000000A; load = 1'b1;
        tick();
        load = 1'b0;
        page_in = 1'b0;
        tick();
        check("lzb_digit0_A", {25'd0, seg}, 32'h08);
        sel_in = 4'b1101;
        tick();
        check("lzb_digit1_blank", {25'd0, seg}, 32'h7F);
        page_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel_in = sels[i];
            tick();
            check("lzb_upper_blank", {25'd0, seg}, 32'h7F);
        end

        sel_in = 4'b1110;
        repeat (8) tick();
        sel_in = 4'b1101;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("blank_window", {28'd0, an}, (i <= 5) ? 32'hF : 32'hD);
        end
        sel_in = 4'b1110;
        repeat (8) tick();
        sel_in = 4'b1101;
        repeat (2) tick();
        sel_in = 4'b1011;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("blank_restart", {28'd0, an}, (i <= 5) ? 32'hF : 32'hB);
        end

        page_in = 1'b0; load = 1'b1; data_in = 32'h88888888; dot_in = 8'h00;
        tick();
        load = 1'b0;
        check("coincident_seg8", {25'd0, seg}, 32'h00);
        check("coincident_pending", {31'd0, pending}, 32'd0);
        sel_in = 4'b1100;
        tick();
        check("invalid_an", {28'd0, an}, 32'hF);
        check("invalid_seg", {25'd0, seg}, 32'h7F);

        for (int c = 0; c < 4000; c++) begin
            rst  = ($urandom_range(0, 499) == 0);
            load = ($urandom_range(0, 15) == 0);
            data_in = $urandom >> $urandom_range(0, 31);
            dot_in  = 8'($urandom);
            if ($urandom_range(0, 49) == 0) page_in = ~page_in;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 5) == 0) sel_in = 4'($urandom);
                else sel_in = sels[$urandom_range(0, 3)];
            end
            tick();
        end
        rst = 1'b0;
        load = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
